// File: rtl/tt_sweep_checker.sv
// Drives all 16 vectors into a 4-input gate, samples its output after a
// settle window, and grades the captured truth table against a constant.
module tt_sweep_checker #(
  parameter logic [15:0] EXPECTED_TT   = 16'h09AF,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        pass,
  output logic [15:0] observed_tt,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_mismatch,
  output logic        first_valid
);

  localparam logic [3:0] LP_S = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_k;
  logic [3:0]  r_cnt;
  logic [15:0] r_obs;
  logic [4:0]  r_mcnt;
  logic [3:0]  r_first;
  logic        r_fv;
  logic        r_pass;
  logic        r_abt;

  logic        w_go;
  logic        w_abort;
  logic        w_sample;
  logic        w_miss;
  logic [3:0]  w_idx;
  logic [15:0] w_obs_nxt;

  assign w_idx    = ~r_k;
  assign w_go     = start & (r_state != HOLD);
  assign w_abort  = abort & (r_state == HOLD);
  assign w_sample = (r_state == HOLD) & ~abort
                  & (r_cnt == LP_S);
  assign w_miss   = dut_out != EXPECTED_TT[w_idx];

  always_comb begin
    w_obs_nxt        = r_obs;
    w_obs_nxt[w_idx] = dut_out;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = HOLD;
      HOLD: begin
        if (abort)
          w_next = IDLE;
        else if (w_sample && r_k == 4'hF)
          w_next = FIN;
      end
      FIN:     w_next = start ? HOLD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // r_k returns to 0 on every exit, so it doubles as dut_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_cnt   <= '0;
      r_obs   <= '0;
      r_mcnt  <= '0;
      r_first <= '0;
      r_fv    <= 1'b0;
      r_pass  <= 1'b0;
      r_abt   <= 1'b0;
    end else if (w_go) begin
      r_k     <= '0;
      r_cnt   <= '0;
      r_obs   <= '0;
      r_mcnt  <= '0;
      r_first <= '0;
      r_fv    <= 1'b0;
      r_pass  <= 1'b0;
      r_abt   <= 1'b0;
    end else if (w_abort) begin
      r_k    <= '0;
      r_cnt  <= '0;
      r_abt  <= 1'b1;
      r_pass <= 1'b0;
    end else if (w_sample) begin
      r_obs <= w_obs_nxt;
      r_cnt <= '0;
      r_k   <= r_k + 4'd1;
      if (w_miss) begin
        r_mcnt <= r_mcnt + 5'd1;
        if (!r_fv) begin
          r_first <= r_k;
          r_fv    <= 1'b1;
        end
      end
      if (r_k == 4'hF)
        r_pass <= (w_obs_nxt == EXPECTED_TT);
    end else if (r_state == HOLD) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign dut_in         = r_k;
  assign busy           = (r_state == HOLD);
  assign done           = (r_state == FIN);
  assign aborted        = r_abt;
  assign pass           = r_pass;
  assign observed_tt    = r_obs;
  assign mismatch_cnt   = r_mcnt;
  assign first_mismatch = r_first;
  assign first_valid    = r_fv;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: gate models, abort, restart,
// asynchronous reset; results graded through an expectation queue.
module tb_tt_sweep_checker;

  localparam logic [15:0] EXP = 16'h09AF;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  first;
    logic        fv;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  dut_in;
  logic        dout;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        pass;
  logic [15:0] observed_tt;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_mismatch;
  logic        first_valid;

  int   n_cmp = 0;
  int   n_err = 0;
  int   tcyc  = 0;
  int   t0    = 0;
  int   mode  = 0;
  exp_t sb[$];

  tt_sweep_checker #(
    .EXPECTED_TT(EXP),
    .SETTLE_CYCLES(2)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .dut_in(dut_in),
    .dut_out(dout),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .pass(pass),
    .observed_tt(observed_tt),
    .mismatch_cnt(mismatch_cnt),
    .first_mismatch(first_mismatch),
    .first_valid(first_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  function automatic logic gate(input logic [3:0] v);
    logic a0, a1, a2, a3;
    a0 = v[3];
    a1 = v[2];
    a2 = v[1];
    a3 = v[0];
    return (a0 & (a1 | ~a3)) | (a1 & ~(a2 ^ a3));
  endfunction

  // mode: 0 ideal, 1 stuck-0, 2 stuck-1, 3 ideal with settle glitches
  always_comb begin
    dout = gate(dut_in);
    if (mode == 1) dout = 1'b0;
    if (mode == 2) dout = 1'b1;
    if (mode == 3 && ((tcyc - t0) % 3) != 0)
      dout = 1'b1;
  end

  function automatic exp_t model(input int m, input int nvec);
    exp_t e;
    logic b;
    e.tt = '0;
    e.cnt = '0;
    e.first = '0;
    e.fv = 1'b0;
    for (int k = 0; k < nvec; k++) begin
      b = (m == 1) ? 1'b0 :
          (m == 2) ? 1'b1 : gate(4'(k));
      e.tt[15-k] = b;
      if (b != EXP[15-k]) begin
        e.cnt = e.cnt + 5'd1;
        if (!e.fv) begin
          e.first = 4'(k);
          e.fv = 1'b1;
        end
      end
    end
    e.pass = (e.tt == EXP);
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".dut_in"}, 32'(dut_in), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".aborted"}, 32'(aborted), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".tt"}, 32'(observed_tt), 0);
    chk({tag, ".mcnt"}, 32'(mismatch_cnt), 0);
    chk({tag, ".first"}, 32'(first_mismatch), 0);
    chk({tag, ".fv"}, 32'(first_valid), 0);
  endtask

  // Called at a negedge; returns at the negedge of the FIN cycle
  // unless hold is set, in which case one more cycle is checked.
  task automatic sweep(input string tag, input int m,
                       input bit mid, input bit pre,
                       input bit hold);
    exp_t e;
    e = model(m, 16);
    mode = m;
    sb.push_back(e);
    if (!pre) begin
      start = 1'b1;
      t0 = tcyc;
    end
    for (int r = 1; r <= 49; r++) begin
      @(negedge clk);
      start = (mid && r == 20);
      if (r == 1) begin
        chk({tag, ".clr_abt"}, 32'(aborted), 0);
        chk({tag, ".clr_tt"}, 32'(observed_tt), 0);
      end
      if (r < 49) begin
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".done_early"}, 32'(done), 0);
        chk({tag, ".dut_in"}, 32'(dut_in), (r - 1) / 3);
      end else begin
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".busy_fin"}, 32'(busy), 0);
        e = sb.pop_front();
        chk({tag, ".tt"}, 32'(observed_tt), 32'(e.tt));
        chk({tag, ".mcnt"}, 32'(mismatch_cnt), 32'(e.cnt));
        chk({tag, ".first"}, 32'(first_mismatch),
            32'(e.first));
        chk({tag, ".fv"}, 32'(first_valid), 32'(e.fv));
        chk({tag, ".pass"}, 32'(pass), 32'(e.pass));
      end
    end
    if (hold) begin
      @(negedge clk);
      chk({tag, ".done_pulse"}, 32'(done), 0);
      chk({tag, ".idle"}, 32'(busy), 0);
      chk({tag, ".hold_tt"}, 32'(observed_tt), 32'(e.tt));
      chk({tag, ".hold_pass"}, 32'(pass), 32'(e.pass));
    end
  endtask

  initial begin
    exp_t p;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    sweep("ideal", 0, 0, 0, 1);
    sweep("stuck0", 1, 0, 0, 1);
    sweep("stuck1", 2, 0, 0, 1);
    sweep("glitch", 3, 0, 0, 1);

    mode = 0;
    start = 1'b1;
    t0 = tcyc;
    for (int r = 1; r <= 17; r++) begin
      @(negedge clk);
      start = (r == 17);
      abort = (r == 17);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    p = model(0, 5);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.flag", 32'(aborted), 1);
    chk("abort.done", 32'(done), 0);
    chk("abort.dut_in", 32'(dut_in), 0);
    chk("abort.tt", 32'(observed_tt), 32'(p.tt));
    chk("abort.mcnt", 32'(mismatch_cnt), 32'(p.cnt));
    chk("abort.pass", 32'(pass), 0);
    repeat (3) @(negedge clk);
    chk("abort.no_done", 32'(done), 0);
    chk("abort.held", 32'(aborted), 1);

    sweep("midstart", 0, 1, 0, 0);
    start = 1'b1;
    t0 = tcyc;
    sweep("finstart", 0, 0, 1, 1);

    mode = 0;
    start = 1'b1;
    t0 = tcyc;
    for (int r = 1; r <= 28; r++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("prerst.dut_in", 32'(dut_in), 9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep("postrst", 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
# tt_sweep_checker

Sequential stimulus-and-capture stage that sits directly upstream of a synthesized 4-input/1-output logic gate netlist. It feeds the gate all 16 input vectors in order, waits a programmable settle time per vector, and samples the gate's single output. It then assembles the observed 16-bit truth table and compares it against an expected hex code (default 0x09AF), reporting pass/fail, mismatch count and the first failing vector.

## Interface

Parameters:
- EXPECTED_TT, 16'h09AF, expected truth table; response to vector k is EXPECTED_TT[15-k].
- SETTLE_CYCLES, 2, extra hold cycles before sampling each vector (S); legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  sweep request; sampled only in IDLE.
- abort  in  1  synchronous abort while busy.
- dut_in  out  4  vector to gate; dut_in[3] drives gate input _0, dut_in[0] drives gate input _3.
- dut_out  in  1  gate output (combinational, treated as settled after S cycles).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse; results valid.
- aborted  out  1  last sweep ended by abort; held until next start.
- pass  out  1  observed_tt == EXPECTED_TT; valid from done.
- observed_tt  out  16  captured table; bit 15-k = dut_out for vector k.
- mismatch_cnt  out  5  count of mismatching vectors, 0..16.
- first_mismatch  out  4  lowest mismatching k.
- first_valid  out  1  at least one mismatch recorded.

## Operation

- FSM states: IDLE, HOLD, FIN.
- IDLE: busy=0, dut_in=0.
  - start=1 → HOLD, k=0, cnt=0.
  - Also clears observed_tt, mismatch_cnt, first_*, pass and aborted.
- HOLD: dut_in=k, busy=1, cnt increments each cycle.
  - On the edge where cnt==S: register dut_out into observed_tt[15-k].
  - If dut_out != EXPECTED_TT[15-k]: mismatch_cnt+1; if first_valid==0, set first_mismatch=k and first_valid=1.
  - Then cnt=0 and k=k+1. k wraps only via exit: after k=15 is sampled → FIN.
- FIN: single cycle. done=1, busy=0, pass=(observed_tt==EXPECTED_TT). Next state is IDLE.
- A start asserted during FIN is honoured: the sweep restarts on the following edge. This is the only start accepted outside IDLE.
- start while in HOLD: ignored.
- abort in HOLD: → IDLE next edge, aborted=1, no done pulse, pass=0. Partial observed_tt and mismatch_cnt are left as captured. abort outside HOLD has no effect.
- abort and start simultaneously in HOLD: abort wins.
- Results hold stable after FIN until the next accepted start.
- rst_n low at any time, including mid-sweep: immediately state=IDLE and every output 0 (dut_in=0, busy, done, aborted, pass, observed_tt, mismatch_cnt, first_mismatch, first_valid).
- mismatch_cnt is 5 bits and cannot overflow (max 16).

## Timing

- Cycle 0 is the cycle start is sampled high in IDLE.
- Cycles 1..S+1: busy=1, dut_in=0. dut_out is sampled at the end of cycle S+1.
- Vector k occupies cycles 1+k(S+1) .. (k+1)(S+1). dut_in is held constant for the whole window.
- FIN (done=1) is cycle 1+16(S+1); for S=2 that is cycle 49.
- The bench sees observed_tt bit updates one cycle after each sample edge.
- dut_out is ignored on all non-sample cycles; glitches during settle have no effect.
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- Ideal 0x09AF gate model (out = _0&(_1|~_3) | _1&(_2 XNOR _3)), S=2, start at cycle 0 → done only at cycle 49, observed_tt=0x09AF, pass=1, mismatch_cnt=0, first_valid=0. dut_in steps 0..15, each held 3 cycles.
- dut_out stuck at 0 → observed_tt=0x0000, mismatch_cnt=8, first_mismatch=4, pass=0.
- dut_out stuck at 1 → observed_tt=0xFFFF, mismatch_cnt=8, first_mismatch=0, pass=0.
- Ideal model plus forced 1 on dut_out during the non-sample cycles of every window → result is identical to the ideal case (pass=1).
- abort while k=5, then a start pulse during HOLD on a separate sweep → abort: busy=0 next cycle, aborted=1, no done. Mid-sweep start: ignored, done still at cycle 49. start during FIN: new sweep begins, dut_in=0 and busy=1 on the next cycle.
- rst_n pulled low at vector 9 (asynchronous, mid-cycle) → all outputs 0 immediately. After release, a new start completes normally with pass=1.
